// File: rtl/sram2s_dp_param.sv
// Two-port synchronous SRAM model with bit write masks, collision flag and a sequential clear engine.
// Define SRAM2S_RST_CLEAR_EN to run the clear engine automatically after every reset.
module sram2s_dp_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    input  logic              WE0,
    input  logic [DATA_W-1:0] WEM0,
    output logic [DATA_W-1:0] Q0,
    output logic              QV0,
    input  logic              CE1,
    input  logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] D1,
    input  logic              WE1,
    input  logic [DATA_W-1:0] WEM1,
    output logic [DATA_W-1:0] Q1,
    output logic              QV1,
    input  logic              CLR_REQ,
    output logic              BUSY,
    output logic              COLL
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              start_req;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc0, acc1, wr0, wr1, same_addr, both_wr;
    logic [DATA_W-1:0] old0, old1, wdata0, wdata1, rdata0, rdata1;
    logic [DATA_W-1:0] q0_s1, q1_s1;
    logic              v0_s1, v1_s1;

`ifdef SRAM2S_RST_CLEAR_EN
    logic init_pend;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            init_pend <= 1'b1;
        else if (state == CLEAR)
            init_pend <= 1'b0;
    end

    assign start_req = CLR_REQ | init_pend;
`else
    assign start_req = CLR_REQ;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state == CLEAR);
        clr_we = (state == CLEAR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (state == CLEAR)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    assign acc0      = CE0 & ~BUSY;
    assign acc1      = CE1 & ~BUSY;
    assign wr0       = acc0 & WE0;
    assign wr1       = acc1 & WE1;
    assign same_addr = (A0 == A1);
    assign both_wr   = wr0 & wr1 & same_addr;
    assign old0      = mem[A0];
    assign old1      = mem[A1];

    // On a shared write port 1 owns every bit it masks; port 0 fills only the bits port 1 leaves alone.
    assign wdata0 = (old0 & ~WEM0) | (D0 & WEM0);
    assign wdata1 = both_wr ? ((old1 & ~(WEM0 | WEM1)) | (D0 & WEM0 & ~WEM1) | (D1 & WEM1))
                            : ((old1 & ~WEM1) | (D1 & WEM1));

    // Write-first only covers a port's own write; a cross-port read always sees the pre-write word.
    assign rdata0 = ((RD_MODE != 0) && wr0) ? (both_wr ? wdata1 : wdata0) : old0;
    assign rdata1 = ((RD_MODE != 0) && wr1) ? wdata1 : old1;

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0 && !both_wr) mem[A0] <= wdata0;
            if (wr1)             mem[A1] <= wdata1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v0_s1 <= 1'b0;
            v1_s1 <= 1'b0;
            q0_s1 <= '0;
            q1_s1 <= '0;
            COLL  <= 1'b0;
        end else begin
            v0_s1 <= acc0;
            v1_s1 <= acc1;
            if (acc0) q0_s1 <= rdata0;
            if (acc1) q1_s1 <= rdata1;
            COLL  <= acc0 & acc1 & same_addr & (wr0 | wr1);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q0_s2, q1_s2;
            logic              v0_s2, v1_s2;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    v0_s2 <= 1'b0;
                    v1_s2 <= 1'b0;
                    q0_s2 <= '0;
                    q1_s2 <= '0;
                end else begin
                    v0_s2 <= v0_s1;
                    v1_s2 <= v1_s1;
                    if (v0_s1) q0_s2 <= q0_s1;
                    if (v1_s1) q1_s2 <= q1_s1;
                end
            end

            assign Q0  = q0_s2;
            assign QV0 = v0_s2;
            assign Q1  = q1_s2;
            assign QV1 = v1_s2;
        end else begin : g_no_out_reg
            assign Q0  = q0_s1;
            assign QV0 = v0_s1;
            assign Q1  = q1_s1;
            assign QV1 = v1_s1;
        end
    endgenerate

endmodule

// File: tb/tb_sram2s_dp_param.sv
// Bench for sram2s_dp_param: a read-first/latency-1 and a write-first/latency-2 instance share one
// stimulus and are compared every cycle against a word-level memory model plus literal spot checks.
`timescale 1ns/1ps
module tb_sram2s_dp_param;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b1;
    logic          CE0, WE0, CE1, WE1, CLR_REQ;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, WEM0, D1, WEM1;

    logic [DW-1:0] q0A, q1A, q0B, q1B;
    logic          qv0A, qv1A, qv0B, qv1B, busyA, busyB, collA, collB;

    int vectors     = 0;
    int miscompares = 0;
    bit cmpOn       = 0;
    int busyCycles;

    always #5 CLK = ~CLK;

    sram2s_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .OUT_REG(0)) dutA (
        .CLK(CLK), .RST_N(RST_N),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(q0A), .QV0(qv0A),
        .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(q1A), .QV1(qv1A),
        .CLR_REQ(CLR_REQ), .BUSY(busyA), .COLL(collA)
    );

    sram2s_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .OUT_REG(1)) dutB (
        .CLK(CLK), .RST_N(RST_N),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(q0B), .QV0(qv0B),
        .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(q1B), .QV1(qv1B),
        .CLR_REQ(CLR_REQ), .BUSY(busyB), .COLL(collB)
    );

    // Model state: word contents with a "known" flag, words still to clear, per-instance expectations.
    logic [DW-1:0] mm [DEPTH];
    bit            mk [DEPTH];
    int            busyLeft;
    bit            initPend;
    bit            expColl, expBusy;
    bit            expV [2][2];
    logic [DW-1:0] expQ [2][2];
    bit            expK [2][2];
    bit            stV [2];
    logic [DW-1:0] stQ [2];
    bit            stK [2];

    bit            mce [2];
    bit            mwe [2];
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];
    logic [DW-1:0] mmask [2];
    logic [DW-1:0] rOld [2];
    logic [DW-1:0] rNew [2];
    bit            kOld [2];
    bit            kNew [2];
    bit            startNow;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busyLeft = 0;
            initPend = 1;
            expColl  = 0;
            expBusy  = 0;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    expV[i][p] = 0;
                    expQ[i][p] = '0;
                    expK[i][p] = 1;
                end
                stV[i] = 0;
                stQ[i] = '0;
                stK[i] = 1;
            end
        end else begin
            mce[0] = CE0 && (busyLeft == 0);
            mce[1] = CE1 && (busyLeft == 0);
            mwe[0] = mce[0] && WE0;
            mwe[1] = mce[1] && WE1;
            ma[0] = A0;   ma[1] = A1;
            md[0] = D0;   md[1] = D1;
            mmask[0] = WEM0;
            mmask[1] = WEM1;
            for (int p = 0; p < 2; p++) begin
                rOld[p] = mm[ma[p]];
                kOld[p] = mk[ma[p]];
            end
            // Apply port 0 then port 1 so port 1 overrides shared bits.
            for (int p = 0; p < 2; p++) begin
                if (mwe[p]) begin
                    mk[ma[p]] = mk[ma[p]] || (mmask[p] == '1);
                    mm[ma[p]] = (mm[ma[p]] & ~mmask[p]) | (md[p] & mmask[p]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                rNew[p] = mm[ma[p]];
                kNew[p] = mk[ma[p]];
            end
            for (int p = 0; p < 2; p++) begin
                expV[0][p] = mce[p];
                if (mce[p]) begin
                    expQ[0][p] = rOld[p];
                    expK[0][p] = kOld[p];
                end
                expV[1][p] = stV[p];
                if (stV[p]) begin
                    expQ[1][p] = stQ[p];
                    expK[1][p] = stK[p];
                end
                stV[p] = mce[p];
                if (mce[p]) begin
                    stQ[p] = mwe[p] ? rNew[p] : rOld[p];
                    stK[p] = mwe[p] ? kNew[p] : kOld[p];
                end
            end
            expColl = mce[0] && mce[1] && (ma[0] == ma[1]) && (mwe[0] || mwe[1]);
`ifdef SRAM2S_RST_CLEAR_EN
            startNow = CLR_REQ || initPend;
`else
            startNow = CLR_REQ;
`endif
            if (busyLeft > 0) begin
                mm[DEPTH - busyLeft] = '0;
                mk[DEPTH - busyLeft] = 1;
                busyLeft--;
            end else if (startNow) begin
                busyLeft = DEPTH;
                initPend = 0;
            end
            expBusy = (busyLeft > 0);
        end
    end

    always @(negedge CLK) begin
        if (cmpOn) begin
            checkOutput("busyA", {31'b0, busyA}, {31'b0, expBusy});
            checkOutput("busyB", {31'b0, busyB}, {31'b0, expBusy});
            checkOutput("collA", {31'b0, collA}, {31'b0, expColl});
            checkOutput("collB", {31'b0, collB}, {31'b0, expColl});
            checkOutput("qv0A", {31'b0, qv0A}, {31'b0, expV[0][0]});
            checkOutput("qv1A", {31'b0, qv1A}, {31'b0, expV[0][1]});
            checkOutput("qv0B", {31'b0, qv0B}, {31'b0, expV[1][0]});
            checkOutput("qv1B", {31'b0, qv1B}, {31'b0, expV[1][1]});
            if (expK[0][0]) checkOutput("q0A", q0A, expQ[0][0]);
            if (expK[0][1]) checkOutput("q1A", q1A, expQ[0][1]);
            if (expK[1][0]) checkOutput("q0B", q0B, expQ[1][0]);
            if (expK[1][1]) checkOutput("q1B", q1B, expQ[1][1]);
        end
    end

    task automatic applyStimulus(input bit ce0, input bit we0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                                 input bit ce1, input bit we1, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d1, input logic [DW-1:0] m1, input bit clr);
        CE0 = ce0; WE0 = we0; A0 = a0; D0 = d0; WEM0 = m0;
        CE1 = ce1; WE1 = we1; A1 = a1; D1 = d1; WEM1 = m1;
        CLR_REQ = clr;
        @(posedge CLK);
        #1;
        CE0 = 0; WE0 = 0; CE1 = 0; WE1 = 0; CLR_REQ = 0;
    endtask

    task automatic waitIdle(input int bound, output int cycles);
        cycles = 0;
        @(negedge CLK);
        while (busyA === 1'b1 && cycles < bound) begin
            cycles++;
            @(negedge CLK);
        end
        checkOutput("busy_bound", {31'b0, busyA}, 32'h0);
    endtask

    initial begin
        CE0 = 0; WE0 = 0; A0 = '0; D0 = '0; WEM0 = '0;
        CE1 = 0; WE1 = 0; A1 = '0; D1 = '0; WEM1 = '0;
        CLR_REQ = 0;
        #1 RST_N = 1'b0;
        #1 cmpOn = 1;

        @(negedge CLK);
        checkOutput("rst_q0A", q0A, 32'h0);
        checkOutput("rst_qv1B", {31'b0, qv1B}, 32'h0);
        checkOutput("rst_busyA", {31'b0, busyA}, 32'h0);
        checkOutput("rst_collB", {31'b0, collB}, 32'h0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
`ifdef SRAM2S_RST_CLEAR_EN
        @(posedge CLK);
        waitIdle(3000, busyCycles);
        checkOutput("auto_clear_len", busyCycles, 32'd1024);
`endif

        // Cross-port read after write, both latencies.
        applyStimulus(1, 1, 10'h010, 32'hA5A5A5A5, '1, 0, 0, '0, '0, '0, 0);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'h010, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t1_q1A", q1A, 32'hA5A5A5A5);
        checkOutput("t1_qv1A", {31'b0, qv1A}, 32'h1);
        checkOutput("t1_qv1B_early", {31'b0, qv1B}, 32'h0);
        @(negedge CLK);
        checkOutput("t1_q1B", q1B, 32'hA5A5A5A5);
        checkOutput("t1_qv1B", {31'b0, qv1B}, 32'h1);

        // Bit-masked merge, then a mask-zero write that must not change the word.
        applyStimulus(1, 1, 10'd5, 32'hFFFF0000, '1, 0, 0, '0, '0, '0, 0);
        applyStimulus(1, 1, 10'd5, 32'h0000FFFF, 32'h00FF00FF, 0, 0, '0, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t2_readfirst", q0A, 32'hFFFF0000);
        applyStimulus(1, 1, 10'd5, 32'h0, 32'h0, 1, 0, 10'd5, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t2_q1A", q1A, 32'hFF0000FF);
        checkOutput("t2_writefirst", q0B, 32'hFF0000FF);
        checkOutput("t2_wem0_old", q0A, 32'hFF0000FF);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, 10'd5, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t2_wem0_keep", q1A, 32'hFF0000FF);

        // Same-address collisions.
        applyStimulus(1, 1, 10'h3FF, 32'h11111111, '1, 1, 1, 10'h3FF, 32'h22222222, '1, 0);
        @(negedge CLK);
        checkOutput("t3_collA", {31'b0, collA}, 32'h1);
        checkOutput("t3_collB", {31'b0, collB}, 32'h1);
        applyStimulus(1, 0, 10'h3FF, '0, '0, 0, 0, '0, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t3_coll_pulse", {31'b0, collA}, 32'h0);
        checkOutput("t3_p1_wins", q0A, 32'h22222222);
        applyStimulus(1, 1, 10'h3FF, 32'hAAAAAAAA, 32'hFFFF0000, 1, 1, 10'h3FF, 32'h55555555, 32'h00FFFF00, 0);
        applyStimulus(1, 1, 10'h3FF, 32'hCAFEF00D, '1, 1, 0, 10'h3FF, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t3_merge_xread", q1A, 32'hAA555522);
        checkOutput("t3_coll_rw", {31'b0, collA}, 32'h1);
        @(negedge CLK);
        checkOutput("t3_xread_wf", q1B, 32'hAA555522);
        applyStimulus(1, 0, 10'h3FF, '0, '0, 0, 0, '0, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t3_final", q0A, 32'hCAFEF00D);

        // Read-during-write mode on the same port.
        applyStimulus(1, 1, 10'd7, 32'h00000001, '1, 0, 0, '0, '0, '0, 0);
        applyStimulus(1, 1, 10'd7, 32'hDEADBEEF, '1, 0, 0, '0, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t4_rd_mode0", q0A, 32'h00000001);
        @(negedge CLK);
        checkOutput("t4_rd_mode1", q0B, 32'hDEADBEEF);

        // Clear engine with an access in the request cycle and a dropped write while busy.
        applyStimulus(1, 1, 10'd2, 32'h00000055, '1, 0, 0, '0, '0, '0, 1);
        busyCycles = 0;
        @(negedge CLK);
        while (busyA === 1'b1 && busyCycles < 2000) begin
            busyCycles++;
            if (busyCycles == 5)
                applyStimulus(1, 1, 10'd9, 32'h0BADF00D, '1, 1, 0, 10'd9, '0, '0, 1);
            @(negedge CLK);
        end
        checkOutput("t5_busy_len", busyCycles, 32'd1024);
        applyStimulus(1, 0, 10'd2, '0, '0, 1, 0, 10'd9, '0, '0, 0);
        @(negedge CLK);
        checkOutput("t5_clr_req_word", q0A, 32'h0);
        checkOutput("t5_dropped_write", q1A, 32'h0);
        for (int i = 0; i < DEPTH / 2; i++)
            applyStimulus(1, 0, AW'(i), '0, '0, 1, 0, AW'(i + DEPTH / 2), '0, '0, 0);
        @(negedge CLK);

        // Reset in the middle of a clear.
        applyStimulus(1, 1, 10'd200, 32'h12345678, '1, 1, 1, 10'd50, 32'h12345678, '1, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1);
        repeat (100) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("t6_busyA_async", {31'b0, busyA}, 32'h0);
        checkOutput("t6_busyB_async", {31'b0, busyB}, 32'h0);
        checkOutput("t6_qv0A_async", {31'b0, qv0A}, 32'h0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
`ifdef SRAM2S_RST_CLEAR_EN
        @(posedge CLK);
        waitIdle(3000, busyCycles);
        checkOutput("t6_auto_clear_len", busyCycles, 32'd1024);
`endif
        applyStimulus(1, 0, 10'd200, '0, '0, 1, 0, 10'd50, '0, '0, 0);
        @(negedge CLK);
`ifdef SRAM2S_RST_CLEAR_EN
        checkOutput("t6_far_word", q0A, 32'h0);
`else
        checkOutput("t6_far_word", q0A, 32'h12345678);
`endif
        checkOutput("t6_near_word", q1A, 32'h0);
        @(negedge CLK);
        @(negedge CLK);

        cmpOn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
